sound_event_sequencer: RTL and testbench

- Game-side transmitter for the audio request interface: accepts single-cycle sound strobes from game logic (four jump directions, win, lose) and serialises them onto the six level request lines consumed by the audio block.
- Emits one request at a time as a clean pulse followed by a guard gap of at least one full sound duration, so queued jumps are heard rather than pre-empted.
- Win/lose take precedence: pending jumps are discarded.

---
 rtl/sound_event_sequencer_if.sv | 31 +++
 rtl/sound_event_sequencer.sv | 166 ++++++++++++++++
 tb/tb_sound_event_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/sound_event_sequencer_if.sv
// Strobe inputs from game logic and level request lines toward the audio block.
interface sound_event_sequencer_if;
    logic       reqForward;
    logic       reqBackward;
    logic       reqRight;
    logic       reqLeft;
    logic       reqWin;
    logic       reqLose;
    logic       jumpForward;
    logic       jumpBackward;
    logic       jumpRight;
    logic       jumpLeft;
    logic       win;
    logic       lose;
    logic       busy;
    logic [7:0] dropCount;

    // Game side: drives strobes, observes the request lines and status.
    modport master (
        output reqForward, reqBackward, reqRight, reqLeft, reqWin, reqLose,
        input  jumpForward, jumpBackward, jumpRight, jumpLeft, win, lose,
        input  busy, dropCount
    );

    // Sequencer side.
    modport slave (
        input  reqForward, reqBackward, reqRight, reqLeft, reqWin, reqLose,
        output jumpForward, jumpBackward, jumpRight, jumpLeft, win, lose,
        output busy, dropCount
    );
endinterface

// File: rtl/sound_event_sequencer.sv
// Serialises single-cycle sound strobes into one-at-a-time request pulses,
// each followed by a guard gap so the audio block plays every queued sound.
// Win/lose flush pending jumps and cut short a jump's guard gap.
module sound_event_sequencer #(
    parameter int HOLD_CYCLES  = 12_500_000,
    parameter int PULSE_CYCLES = 4,
    parameter int DEPTH        = 4
) (
    input logic               clk,
    input logic               reset,
    sound_event_sequencer_if.slave bus
);
    localparam int MAXC = (HOLD_CYCLES > PULSE_CYCLES) ? HOLD_CYCLES : PULSE_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int AW   = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [2:0]    mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_n, rd_n;
    logic [1:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    cur, cur_n;
    logic          abort_pend, abort_n, abort_now;
    logic [5:0]    outs, outs_n;
    logic          busy_q, busy_n;
    logic [7:0]    drop_q, drop_n;

    logic [5:0]    strb;
    logic [2:0]    sel, n_strb, extra;
    logic          is_ctrl, is_jump, jump_ok, jump_drop;
    logic          empty, full, pop;
    logic [2:0]    head;
    logic [8:0]    dsum;

    // Bit index equals the event code, so higher index wins on collisions.
    assign strb = {bus.reqLose, bus.reqWin, bus.reqLeft,
                   bus.reqRight, bus.reqBackward, bus.reqForward};

    // Pick the highest-priority strobe and count the losers.
    always_comb begin
        sel    = '0;
        n_strb = '0;
        for (int i = 0; i < 6; i++) begin
            if (strb[i]) begin
                sel    = 3'(i);
                n_strb = n_strb + 3'd1;
            end
        end
    end

    assign extra   = (n_strb == 3'd0) ? 3'd0 : n_strb - 3'd1;
    assign is_ctrl = (n_strb != 3'd0) && sel[2];
    assign is_jump = (n_strb != 3'd0) && !sel[2];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = (state == ST_IDLE) && !empty;
    assign head  = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees a slot for an incoming jump.
    assign jump_ok   = is_jump && (!full || pop);
    assign jump_drop = is_jump && !jump_ok;

    assign dsum   = 9'(drop_q) + 9'(extra) + 9'(jump_drop);
    assign drop_n = (dsum > 9'd255) ? 8'd255 : dsum[7:0];

    // Win/lose collapses the FIFO to a single entry; the head (if popped
    // this cycle) has already been captured into cur.
    always_comb begin
        wr_n = wr_ptr;
        rd_n = rd_ptr;
        if (is_ctrl) begin
            rd_n = wr_ptr;
            wr_n = wr_ptr + 1'b1;
        end else begin
            rd_n = rd_ptr + (AW+1)'(pop);
            wr_n = wr_ptr + (AW+1)'(jump_ok);
        end
    end

    // Sequencer FSM: IDLE pops and starts a pulse, PULSE times the line,
    // GAP holds silence unless a win/lose pre-empts a jump's gap.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        cur_n     = cur;
        abort_n   = abort_pend;
        outs_n    = outs;
        abort_now = abort_pend || (is_ctrl && !cur[2]);
        case (state)
            ST_IDLE: begin
                if (pop) begin
                    cur_n   = head;
                    outs_n  = 6'b000001 << head;
                    cnt_n   = CW'(PULSE_CYCLES - 1);
                    state_n = ST_PULSE;
                    abort_n = is_ctrl && !head[2];
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    outs_n  = '0;
                    abort_n = 1'b0;
                    if (abort_now) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_GAP;
                        cnt_n   = CW'(HOLD_CYCLES - 1);
                    end
                end else begin
                    cnt_n   = cnt - 1'b1;
                    abort_n = abort_now;
                end
            end
            ST_GAP: begin
                if ((is_ctrl && !cur[2]) || cnt == '0) state_n = ST_IDLE;
                else                                  cnt_n   = cnt - 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy_n = (state_n != ST_IDLE) || (wr_n != rd_n);

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (is_ctrl || jump_ok) mem[wr_ptr[AW-1:0]] <= sel;
    end

    // Registered state and all outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            state      <= ST_IDLE;
            cnt        <= '0;
            cur        <= '0;
            abort_pend <= 1'b0;
            outs       <= '0;
            busy_q     <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr     <= wr_n;
            rd_ptr     <= rd_n;
            state      <= state_n;
            cnt        <= cnt_n;
            cur        <= cur_n;
            abort_pend <= abort_n;
            outs       <= outs_n;
            busy_q     <= busy_n;
            drop_q     <= drop_n;
        end
    end

    assign bus.jumpForward  = outs[0];
    assign bus.jumpBackward = outs[1];
    assign bus.jumpRight    = outs[2];
    assign bus.jumpLeft     = outs[3];
    assign bus.win          = outs[4];
    assign bus.lose         = outs[5];
    assign bus.busy         = busy_q;
    assign bus.dropCount    = drop_q;
endmodule

// File: tb/tb_sound_event_sequencer.sv
// Bench for sound_event_sequencer: a timestamp-based reference model predicts
// each pulse (code + start cycle), levels, busy and dropCount; a negedge
// monitor compares the DUT against it.
module tb_sound_event_sequencer;
    localparam int H = 20;
    localparam int P = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sound_event_sequencer_if bus();

    sound_event_sequencer #(.HOLD_CYCLES(H), .PULSE_CYCLES(P), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [5:0] strb_v, outs_v;
    assign strb_v = {bus.reqLose, bus.reqWin, bus.reqLeft, bus.reqRight, bus.reqBackward, bus.reqForward};
    assign outs_v = {bus.lose, bus.win, bus.jumpLeft, bus.jumpRight, bus.jumpBackward, bus.jumpForward};

    typedef struct { int code; int cyc; } ev_t;
    ev_t  sb[$];
    int   q[$];
    int   cyc = 0;
    int   next_pop, e_start, cur, dc;
    bit   cur_valid;
    logic [5:0] exp_lv;
    bit   exp_busy;

    // Reference model: a queue of codes plus "earliest next pop" timestamps.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete(); sb.delete();
            next_pop = 0; e_start = 0; cur = 0; cur_valid = 0; dc = 0;
            exp_lv = '0; exp_busy = 0;
        end else begin
            int t, n, code, drops, a;
            t = cyc;
            if (q.size() > 0 && t >= next_pop) begin
                cur = q.pop_front(); cur_valid = 1; e_start = t;
                next_pop = t + P + H + 1;
                sb.push_back('{cur, t});
            end
            n = $countones(strb_v);
            if (n > 0) begin
                code = 0;
                for (int i = 0; i < 6; i++) if (strb_v[i]) code = i;
                drops = n - 1;
                if (code >= 4) begin
                    q.delete(); q.push_back(code);
                    if (cur_valid && cur < 4) begin
                        a = ((t > e_start + P) ? t : e_start + P) + 1;
                        if (a < next_pop) next_pop = a;
                    end
                end else if (q.size() < D) q.push_back(code);
                else drops++;
                dc = dc + drops;
                if (dc > 255) dc = 255;
            end
            exp_lv   = (cur_valid && t < e_start + P) ? (6'b000001 << cur) : 6'b0;
            exp_busy = (q.size() > 0) || (t < next_pop - 1);
            cyc++;
        end
    end

    // Monitor: per-cycle level/status compare, plus scoreboard pop on each rising pulse.
    logic [5:0] prev_out = '0;
    always @(negedge clk) begin
        if (reset) prev_out <= '0;
        else begin
            check("levels", outs_v, exp_lv);
            check("busy", bus.busy, exp_busy);
            check("dropCount", bus.dropCount, dc);
            if ((outs_v & ~prev_out) != 0) begin
                int oc;
                ev_t ev;
                oc = 0;
                for (int i = 0; i < 6; i++) if (outs_v[i]) oc = i;
                if (sb.size() == 0) check("unexpected_pulse", oc, -1);
                else begin
                    ev = sb.pop_front();
                    check("pulse_code", oc, ev.code);
                    check("pulse_cycle", cyc - 1, ev.cyc);
                end
            end
            prev_out <= outs_v;
        end
    end

    task automatic drive(input logic [5:0] m);
        @(negedge clk);
        {bus.reqLose, bus.reqWin, bus.reqLeft, bus.reqRight, bus.reqBackward, bus.reqForward} = m;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(6'b0);
    endtask

    task automatic do_reset();
        drive(6'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain();
        int k;
        drive(6'b0);
        k = 0;
        while ((bus.busy || outs_v != 0) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) check("drain_timeout", k, 0);
        idle(2);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        {bus.reqLose, bus.reqWin, bus.reqLeft, bus.reqRight, bus.reqBackward, bus.reqForward} = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs_v, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_drop", bus.dropCount, 0);
        reset = 1'b0;

        // Single forward jump.
        idle(9);
        drive(6'b000001);
        drain();
        check("t1_drop", bus.dropCount, 0);

        // Six consecutive strobes; the last hits a full FIFO.
        drive(6'b000001); drive(6'b000010); drive(6'b000100);
        drive(6'b001000); drive(6'b000001); drive(6'b000001);
        drain();
        check("t2_drop", bus.dropCount, 1);

        // Same-cycle fwd + lose.
        do_reset();
        drive(6'b100001);
        drain();
        check("t3_drop", bus.dropCount, 1);

        // Win during a jump's gap aborts it and flushes the rest.
        do_reset();
        drive(6'b000001); drive(6'b000010); drive(6'b000100);
        idle(8);
        drive(6'b010000);
        drain();

        // Win during lose's gap waits out the gap.
        do_reset();
        drive(6'b100000);
        idle(4);
        drive(6'b010000);
        drain();

        // Async reset mid-pulse with two entries queued.
        do_reset();
        drive(6'b000001); drive(6'b000010); drive(6'b000100);
        @(posedge clk);
        #2;
        check("t6_pre_pulse", bus.jumpForward, 1);
        {bus.reqLose, bus.reqWin, bus.reqLeft, bus.reqRight, bus.reqBackward, bus.reqForward} = '0;
        reset = 1'b1;
        #1;
        check("t6_async_outs", outs_v, 0);
        check("t6_async_busy", bus.busy, 0);
        check("t6_async_drop", bus.dropCount, 0);
        @(negedge clk);
        reset = 1'b0;
        idle(40);
        check("t6_no_pulse_outs", outs_v, 0);
        check("t6_no_pending", sb.size(), 0);

        // dropCount saturation: all six strobes every cycle.
        do_reset();
        repeat (60) drive(6'h3f);
        drain();
        check("sat_drop", bus.dropCount, 255);

        // Randomized traffic.
        do_reset();
        repeat (2500) begin
            int r;
            r = $urandom_range(0, 15);
            if (r < 2)                                  drive(6'($urandom_range(1, 15)));
            else if (r == 2 && $urandom_range(0, 3) == 0) drive(6'($urandom_range(1, 63)));
            else                                        drive(6'b0);
        end
        drain();
        check("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
